// File: rtl/memory_access_mux.sv
// Memory-stage access decoder: turns the instruction opcode into data-memory strobes,
// address and store data, and counts the clock cycles that carry a memory access.
module memory_access_mux #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] instr,
    input  logic [DWIDTH-1:0] data_ula,
    input  logic [DWIDTH-1:0] register_data,
    output logic [DWIDTH-1:0] data_out,
    output logic [AWIDTH-1:0] addr,
    output logic              read_enable,
    output logic              write_enable,
    output logic [15:0]       access_count
);

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_LOAD,
        ACC_STORE
    } access_e;

    localparam logic [4:0] OP_LW = 5'b00000;
    localparam logic [4:0] OP_SW = 5'b00001;

    access_e     access;
    logic [DWIDTH-1:0] store_data;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    // The case statement matches exactly, so an X/Z opcode lands in the idle default.
    always_comb begin
        access = ACC_IDLE;
        if (!reset) begin
            case (instr[DWIDTH-1 -: 5])
                OP_LW:   access = ACC_LOAD;
                OP_SW:   access = ACC_STORE;
                default: access = ACC_IDLE;
            endcase
        end
    end

    // Enables come from a single encoded access kind, so they can never both be high.
    assign read_enable  = (access == ACC_LOAD);
    assign write_enable = (access == ACC_STORE);

    // Address is released when idle; upper ALU bits are silently dropped.
    assign addr = (access == ACC_IDLE) ? {AWIDTH{1'bz}} : data_ula[AWIDTH-1:0];

    // A load releases the data bus so the memory can drive it back.
    assign store_data = (access == ACC_STORE) ? register_data : {DWIDTH{1'b0}};
    assign data_out   = (access == ACC_LOAD) ? {DWIDTH{1'bz}} : store_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // The enables are already forced low under reset, so an edge coincident with reset never counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_count <= 16'h0000;
        end else if (read_enable || write_enable) begin
            access_count <= access_count + 16'h0001;
        end
    end

    // Opcode-only decode and address truncation leave these bits intentionally unread.
    logic unused_bits;
    assign unused_bits = &{1'b0, instr[DWIDTH-6:0], data_ula[DWIDTH-1:AWIDTH]};

endmodule

// File: tb/tb_memory_access_mux.sv
// Directed bench for memory_access_mux: decode of LW/SW/idle, truncation, reset override,
// and the access counter including its 16-bit wrap.
module tb_memory_access_mux;

    localparam int AWIDTH = 15;
    localparam int DWIDTH = 32;

    // Released (Z) bus bits read back as 1 through the weak pullups below.
    localparam logic [AWIDTH-1:0] ADDR_REL = {AWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] DATA_REL = {DWIDTH{1'b1}};

    logic              clk;
    logic              reset;
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH-1:0] data_ula;
    logic [DWIDTH-1:0] register_data;
    wire  [DWIDTH-1:0] data_out;
    wire  [AWIDTH-1:0] addr;
    logic              read_enable;
    logic              write_enable;
    logic [15:0]       access_count;

    pullup (data_out);
    pullup (addr);

    int total;
    int bad;

    memory_access_mux #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .data_ula     (data_ula),
        .register_data(register_data),
        .data_out     (data_out),
        .addr         (addr),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .access_count (access_count)
    );

    // One full clock period; outputs are sampled with clk low, away from the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        logic [64:0] obs, exp;
        reset = 1'b1; instr = 32'h0800_0000; data_ula = 32'h0000_1234; register_data = 32'hDEAD_BEEF;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b0, ADDR_REL, 32'h0000_0000, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_state: got re/we/addr/data/cnt=%h want %h", obs, exp);
        end
        reset = 1'b0;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b1, 15'h1234, 32'hDEAD_BEEF, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_lw;
        logic [64:0] obs, exp;
        instr = 32'h0000_0000; data_ula = 32'h0000_0000; register_data = 32'h5555_5555;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b1, 1'b0, 15'h0000, DATA_REL, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL lw_zero: got %h want %h", obs, exp);
        end
        instr = 32'h07FF_FFFF; data_ula = 32'h0000_1234;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b1, 1'b0, 15'h1234, DATA_REL, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL lw_low_bits_ignored: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_sw;
        logic [64:0] obs, exp;
        instr = 32'h0800_0000; data_ula = 32'h0000_0000; register_data = 32'h0000_0001;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b1, 15'h0000, 32'h0000_0001, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL sw_basic: got %h want %h", obs, exp);
        end
        instr = 32'h0FFF_FFFF; data_ula = 32'h0000_7FFF; register_data = 32'hA5A5_0000;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b1, 15'h7FFF, 32'hA5A5_0000, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL sw_pattern: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_default;
        logic [31:0] ops [3] = '{32'h3800_0000, 32'hF800_0000, 32'h1000_0000};
        logic [64:0] obs, exp;
        data_ula = 32'h0000_0000; register_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            instr = ops[i];
            #1;
            obs = {read_enable, write_enable, addr, data_out, access_count};
            exp = {1'b0, 1'b0, ADDR_REL, 32'h0000_0000, 16'h0000};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL default_op[%0d] instr=%h: got %h want %h", i, ops[i], obs, exp);
            end
        end
    endtask

    task automatic test_truncation;
        instr = 32'h0000_0000; data_ula = 32'hFFFF_8005;
        #1;
        total++;
        if (addr !== 15'h0005) begin
            bad++;
            $display("FAIL trunc_lw: got addr=%h want 0005", addr);
        end
        instr = 32'h0800_0000; data_ula = 32'h0001_7FFE;
        #1;
        total++;
        if (addr !== 15'h7FFE) begin
            bad++;
            $display("FAIL trunc_sw: got addr=%h want 7ffe", addr);
        end
    endtask

    task automatic test_counter;
        instr = 32'h0000_0000; data_ula = 32'h0000_0010;
        tick(3);
        total++;
        if (access_count !== 16'd3) begin
            bad++;
            $display("FAIL count_lw3: got %0d want 3", access_count);
        end
        instr = 32'h3800_0000;
        tick(2);
        total++;
        if (access_count !== 16'd3) begin
            bad++;
            $display("FAIL count_idle_hold: got %0d want 3", access_count);
        end
        instr = 32'h0800_0000;
        tick(1);
        total++;
        if (access_count !== 16'd4) begin
            bad++;
            $display("FAIL count_sw: got %0d want 4", access_count);
        end
    endtask

    task automatic test_reset_override;
        logic [64:0] obs, exp;
        instr = 32'h0800_0000; data_ula = 32'h0000_0042; register_data = 32'hCAFE_F00D;
        reset = 1'b1;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b0, ADDR_REL, 32'h0000_0000, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_async_override: got %h want %h", obs, exp);
        end
        tick(1);
        total++;
        if (access_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_edge_no_count: got %0d want 0", access_count);
        end
        reset = 1'b0;
        #1;
        obs = {read_enable, write_enable, addr, data_out, access_count};
        exp = {1'b0, 1'b1, 15'h0042, 32'hCAFE_F00D, 16'h0000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_resume_decode: got %h want %h", obs, exp);
        end
        tick(1);
        total++;
        if (access_count !== 16'd1) begin
            bad++;
            $display("FAIL count_after_reset: got %0d want 1", access_count);
        end
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        instr = 32'h0000_0000;
        tick(65535);
        total++;
        if (access_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL count_max: got %h want ffff", access_count);
        end
        tick(1);
        total++;
        if (access_count !== 16'h0000) begin
            bad++;
            $display("FAIL count_wrap: got %h want 0000", access_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        instr = '0; data_ula = '0; register_data = '0;
        #2;
        test_reset;
        test_lw;
        test_sw;
        test_default;
        test_truncation;
        test_counter;
        test_reset_override;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
